vend_dispense_ctrl: RTL and testbench

Sequences the physical side of the cola vending machine.
- Accumulates credit from debounced one-cycle coin pulses (0.5 and 1.0 units).
- Once credit reaches the price, it drives a can-dispenser handshake, then returns change one 0.5-coin at a time over a second handshake.
- Refunds the full credit on cancel or inactivity.
- Sits between the key debouncers and the dispenser/coin-hopper actuators, and drives the 8-LED credit display.

---
 rtl/vend_pkg.sv | 47 ++++
 rtl/vend_dispense_ctrl_if.sv | 29 ++
 rtl/vend_hs_port.sv | 100 ++++++++++
 rtl/vend_dispense_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense controller.
// Holds the top-level state encoding, the handshake-port phase encoding,
// the coin unit values, the credit width, the debug struct exported by the
// top, and the LED thermometer helper.
package vend_pkg;

    // Credit register width, in 0.5 units.
    localparam int CREDIT_W = 4;

    // Coin values in 0.5 units.
    localparam logic [2:0] UNIT05 = 3'd1;
    localparam logic [2:0] UNIT10 = 3'd2;

    // Controller states.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_DROP    = 3'd2;
    localparam logic [2:0] ST_CHANGE  = 3'd3;
    localparam logic [2:0] ST_REFUND  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_FAULT   = 3'd6;

    // 4-phase master phases.
    localparam logic [1:0] HS_IDLE     = 2'd0;
    localparam logic [1:0] HS_WAIT_LOW = 2'd1;
    localparam logic [1:0] HS_REQ      = 2'd2;
    localparam logic [1:0] HS_REL      = 2'd3;

    typedef struct packed {
        logic [2:0] state;
        logic [1:0] drop_phase;
        logic [1:0] chg_phase;
        logic       drop_ack_hi;
        logic       chg_ack_hi;
    } vend_dbg_t;

    // Thermometer code: bit i lit when credit > i, saturating at 0xFF.
    function automatic logic [7:0] thermo8(input logic [CREDIT_W-1:0] c);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (c > CREDIT_W'(i)) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Actuator handshake bundle between the dispense controller and the
// can dispenser / coin hopper.
//   drop_req/drop_ack : can-dispense request and acknowledge
//   chg_req/chg_ack   : return-one-0.5-coin request and acknowledge
// Handshake semantics (both pairs): 4-phase. The master raises req only
// while ack is low, holds req until it samples ack high, drops req on the
// following cycle, and the transfer is complete when it then samples ack
// low. The slave raises ack in response to req and lowers it after req
// falls. At most one req of the bundle is high at any time.
interface vend_dispense_ctrl_if;
    logic drop_req;
    logic drop_ack;
    logic chg_req;
    logic chg_ack;

    modport master (
        output drop_req,
        input  drop_ack,
        output chg_req,
        input  chg_ack
    );

    modport slave (
        input  drop_req,
        output drop_ack,
        input  chg_req,
        output chg_ack
    );
endinterface

// File: rtl/vend_hs_port.sv
// One 4-phase req/ack master.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begin a transfer (ignored unless idle)
//   ack        : slave acknowledge level
//   req        : registered request to the slave
//   ack_hi     : high in the cycle where ack is sampled high with req up
//   done       : high in the cycle where the final ack-low is sampled
//   timeout    : high in the cycle a wait on an ack level expires
//   phase      : current phase, for debug
// ack_hi, done and timeout are combinational so the owner reacts on the
// same clock edge the port acts on.
module vend_hs_port
    import vend_pkg::*;
#(
    parameter int ACK_TO_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ack,
    output logic       req,
    output logic       ack_hi,
    output logic       done,
    output logic       timeout,
    output logic [1:0] phase
);
    localparam int TW = $clog2(ACK_TO_CYC + 1);

    logic [TW-1:0] wait_cnt;
    logic          satisfied;
    logic          expired;

    always_comb begin
        satisfied = 1'b0;
        case (phase)
            HS_WAIT_LOW: satisfied = !ack;
            HS_REQ:      satisfied = ack;
            HS_REL:      satisfied = !ack;
            default:     satisfied = 1'b0;
        endcase
        expired = (wait_cnt == TW'(ACK_TO_CYC - 1));
        ack_hi  = (phase == HS_REQ) && ack;
        done    = (phase == HS_REL) && !ack;
        timeout = (phase != HS_IDLE) && !satisfied && expired;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= HS_IDLE;
            req      <= 1'b0;
            wait_cnt <= '0;
        end else if (timeout) begin
            phase    <= HS_IDLE;
            req      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (phase)
                HS_IDLE: begin
                    wait_cnt <= '0;
                    if (start) begin
                        // Skip the low-wait when ack is already idle.
                        if (!ack) begin
                            req   <= 1'b1;
                            phase <= HS_REQ;
                        end else begin
                            phase <= HS_WAIT_LOW;
                        end
                    end
                end
                HS_WAIT_LOW: begin
                    if (!ack) begin
                        req      <= 1'b1;
                        phase    <= HS_REQ;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HS_REQ: begin
                    if (ack) begin
                        req      <= 1'b0;
                        phase    <= HS_REL;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HS_REL: begin
                    if (!ack) begin
                        phase    <= HS_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: phase <= HS_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: accumulates coin credit, drives the can
// dispenser once the price is reached, pays change / refunds one 0.5 coin
// per hopper handshake, and drives the 8-LED credit display.
//   clk, rst_n      : clock, asynchronous active-low reset
//   coin05, coin10  : one-cycle coin-accepted pulses (0.5 / 1.0 units)
//   cancel          : one-cycle refund request
//   hs              : dispenser and hopper 4-phase handshakes (master side)
//   credit          : current credit in 0.5 units
//   coin_rej        : one-cycle pulse, a coin arrived while not accepting
//   vend_done       : high while the DONE indication is shown
//   fault           : sticky, an acknowledge timed out
//   led             : registered display
//   dbg             : state and handshake phases for observation
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE       = 5,
    parameter int IDLE_TO_CYC = 250_000_000,
    parameter int ACK_TO_CYC  = 50_000_000,
    parameter int DONE_CYC    = 25_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin05,
    input  logic                coin10,
    input  logic                cancel,
    vend_dispense_ctrl_if.master hs,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_rej,
    output logic                vend_done,
    output logic                fault,
    output logic [7:0]          led,
    output vend_dbg_t           dbg
);
    // Highest credit is PRICE-1 plus a simultaneous 0.5+1.0 pulse.
    if (PRICE + 2 > (2 ** CREDIT_W) - 1) begin : g_price_check
        $error("PRICE too large for the credit register");
    end

    localparam int IW        = $clog2(IDLE_TO_CYC + 1);
    localparam int DW        = $clog2(DONE_CYC + 1);
    localparam int BLINK_CYC = (DONE_CYC / 4 > 0) ? DONE_CYC / 4 : 1;
    localparam int BW        = $clog2(BLINK_CYC + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   PRICE_EXT = (CREDIT_W + 1)'(PRICE);

    logic [2:0]          state;
    logic [IW-1:0]       idle_cnt;
    logic [DW-1:0]       done_cnt;
    logic [BW-1:0]       blink_cnt;
    logic                blink_ph;
    logic                drop_start, chg_start;
    logic                drop_ack_hi, drop_done, drop_to;
    logic                chg_ack_hi, chg_done, chg_to;
    logic [1:0]          drop_phase, chg_phase;
    logic [2:0]          coin_v;
    logic [CREDIT_W:0]   credit_sum;
    logic                accepting;

    always_comb begin
        coin_v     = (coin05 ? UNIT05 : 3'd0) + (coin10 ? UNIT10 : 3'd0);
        credit_sum = {1'b0, credit} + (CREDIT_W + 1)'(coin_v);
        accepting  = (state == ST_IDLE) || (state == ST_COLLECT);
    end

    vend_hs_port #(.ACK_TO_CYC(ACK_TO_CYC)) u_drop (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (drop_start),
        .ack     (hs.drop_ack),
        .req     (hs.drop_req),
        .ack_hi  (drop_ack_hi),
        .done    (drop_done),
        .timeout (drop_to),
        .phase   (drop_phase)
    );

    vend_hs_port #(.ACK_TO_CYC(ACK_TO_CYC)) u_chg (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (chg_start),
        .ack     (hs.chg_ack),
        .req     (hs.chg_req),
        .ack_hi  (chg_ack_hi),
        .done    (chg_done),
        .timeout (chg_to),
        .phase   (chg_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            credit     <= '0;
            idle_cnt   <= '0;
            drop_start <= 1'b0;
            chg_start  <= 1'b0;
            coin_rej   <= 1'b0;
        end else begin
            drop_start <= 1'b0;
            chg_start  <= 1'b0;
            coin_rej   <= !accepting && (coin_v != 3'd0);
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (coin_v != 3'd0) begin
                        credit <= CREDIT_W'(coin_v);
                        state  <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    credit <= credit_sum[CREDIT_W-1:0];
                    if (coin_v != 3'd0) idle_cnt <= '0;
                    else                idle_cnt <= idle_cnt + 1'b1;
                    // Reaching the price wins over a same-cycle cancel.
                    if (credit_sum >= PRICE_EXT) begin
                        state      <= ST_DROP;
                        drop_start <= 1'b1;
                    end else if (cancel ||
                                 (coin_v == 3'd0 && idle_cnt == IW'(IDLE_TO_CYC - 1))) begin
                        state     <= ST_REFUND;
                        chg_start <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (drop_to) begin
                        state <= ST_FAULT;
                    end else if (drop_done) begin
                        if (credit > PRICE_C) begin
                            credit    <= credit - PRICE_C;
                            state     <= ST_CHANGE;
                            chg_start <= 1'b1;
                        end else begin
                            credit <= '0;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_CHANGE, ST_REFUND: begin
                    if (chg_to) begin
                        state <= ST_FAULT;
                    end else begin
                        if (chg_ack_hi) credit <= credit - 1'b1;
                        // ack_hi always precedes done, so credit is current here.
                        if (chg_done) begin
                            if (credit == '0)
                                state <= (state == ST_CHANGE) ? ST_DONE : ST_IDLE;
                            else
                                chg_start <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (done_cnt == DW'(DONE_CYC - 1)) state <= ST_IDLE;
                end
                ST_FAULT: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // DONE hold timer and LED blink phase, restarted on every DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt  <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (state != ST_DONE) begin
            done_cnt  <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            done_cnt <= done_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_CYC - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= 8'h00;
        end else begin
            case (state)
                ST_COLLECT, ST_DROP, ST_CHANGE, ST_REFUND: led <= thermo8(credit);
                ST_DONE:  led <= blink_ph ? 8'h0F : 8'hF0;
                ST_FAULT: led <= 8'hFF;
                default:  led <= 8'h00;
            endcase
        end
    end

    always_comb begin
        vend_done       = (state == ST_DONE);
        fault           = (state == ST_FAULT);
        dbg.state       = state;
        dbg.drop_phase  = drop_phase;
        dbg.chg_phase   = chg_phase;
        dbg.drop_ack_hi = drop_ack_hi;
        dbg.chg_ack_hi  = chg_ack_hi;
    end
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
module tb_vend_dispense_ctrl;
    import vend_pkg::*;

    localparam int PRICE    = 5;
    localparam int IDLE_TO  = 100;
    localparam int ACK_TO   = 20;
    localparam int DONE_CYC = 8;
    localparam int EXP_BLINK_CHG = (DONE_CYC - 2) / (DONE_CYC / 4);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       coin05 = 1'b0;
    logic       coin10 = 1'b0;
    logic       cancel = 1'b0;
    logic [3:0] credit;
    logic       coin_rej, vend_done, fault;
    logic [7:0] led;
    vend_dbg_t  dbg;

    vend_dispense_ctrl_if hs_bus();

    vend_dispense_ctrl #(
        .PRICE       (PRICE),
        .IDLE_TO_CYC (IDLE_TO),
        .ACK_TO_CYC  (ACK_TO),
        .DONE_CYC    (DONE_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coin05    (coin05),
        .coin10    (coin10),
        .cancel    (cancel),
        .hs        (hs_bus),
        .credit    (credit),
        .coin_rej  (coin_rej),
        .vend_done (vend_done),
        .fault     (fault),
        .led       (led),
        .dbg       (dbg)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    int cq[$];

    int ack_dly = 3;
    bit resp_en = 1'b1;

    int drop_cnt, chg_cnt, done_cyc_cnt, overlap_cnt, blink_samples, blink_changes;
    logic [7:0] last_blink;
    logic prev_drop = 1'b0;
    logic prev_chg  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        drop_cnt = 0; chg_cnt = 0; done_cyc_cnt = 0; overlap_cnt = 0;
        blink_samples = 0; blink_changes = 0; last_blink = 8'h00;
    endtask

    task automatic load(input int n, input int a, input int b, input int c);
        cq.delete();
        if (n > 0) cq.push_back(a);
        if (n > 1) cq.push_back(b);
        if (n > 2) cq.push_back(c);
    endtask

    function automatic logic [7:0] thermo_ref(input int c);
        if (c >= 8) return 8'hFF;
        return 8'((1 << c) - 1);
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (dbg.state != ST_IDLE && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(dbg.state), 32'(ST_IDLE));
    endtask

    // Plays the coin list in cq; the model stops taking coins once the price
    // is met. Paid: one drop, change = sum - PRICE, DONE for DONE_CYC cycles.
    // Not paid (cancel or inactivity): refund of the whole sum, no DONE.
    task automatic run_txn(input string name, input bit want_cancel);
        int sum, n_used, v, exp_chg;
        bit paid;
        logic [3:0] e;
        sum = 0; n_used = 0;
        foreach (cq[i]) begin
            if (sum < PRICE) begin
                sum += cq[i];
                n_used++;
                exp_q.push_back(4'(sum));
            end
        end
        paid    = (sum >= PRICE);
        exp_chg = paid ? sum - PRICE : sum;
        clr_counts();
        for (int i = 0; i < n_used; i++) begin
            v = cq[i];
            coin05 = v[0];
            coin10 = v[1];
            step();
            coin05 = 1'b0;
            coin10 = 1'b0;
            e = exp_q.pop_front();
            check({name, ":credit"}, 32'(credit), 32'(e));
            step();
            check({name, ":led"}, 32'(led), 32'(thermo_ref(int'(e))));
            repeat ($urandom_range(0, 2)) step();
        end
        if (want_cancel && !paid) begin
            cancel = 1'b1;
            step();
            cancel = 1'b0;
        end
        wait_idle({name, ":idle"}, 400);
        step();
        check({name, ":led_idle"}, 32'(led), 32'h00);
        check({name, ":credit_end"}, 32'(credit), 32'd0);
        check({name, ":drops"}, 32'(drop_cnt), paid ? 32'd1 : 32'd0);
        check({name, ":chg"}, 32'(chg_cnt), 32'(exp_chg));
        check({name, ":done_cyc"}, 32'(done_cyc_cnt), paid ? 32'(DONE_CYC) : 32'd0);
        if (paid) begin
            check({name, ":blink_n"}, 32'(blink_samples), 32'(DONE_CYC - 1));
            check({name, ":blink_chg"}, 32'(blink_changes), 32'(EXP_BLINK_CHG));
        end
        check({name, ":overlap"}, 32'(overlap_cnt), 32'd0);
    endtask

    // ---------------- slave responders ----------------
    initial begin : drop_resp
        int w;
        w = 0;
        hs_bus.drop_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (hs_bus.drop_req && !hs_bus.drop_ack && resp_en) begin
                w++;
                if (w >= ack_dly) begin
                    hs_bus.drop_ack = 1'b1;
                    w = 0;
                end
            end else if (!hs_bus.drop_req && hs_bus.drop_ack) begin
                hs_bus.drop_ack = 1'b0;
            end
        end
    end

    initial begin : chg_resp
        int w;
        w = 0;
        hs_bus.chg_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (hs_bus.chg_req && !hs_bus.chg_ack && resp_en) begin
                w++;
                if (w >= ack_dly) begin
                    hs_bus.chg_ack = 1'b1;
                    w = 0;
                end
            end else if (!hs_bus.chg_req && hs_bus.chg_ack) begin
                hs_bus.chg_ack = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (hs_bus.drop_req && !prev_drop) drop_cnt++;
            if (hs_bus.chg_req && !prev_chg) chg_cnt++;
            if (hs_bus.drop_req && hs_bus.chg_req) overlap_cnt++;
            if (vend_done) begin
                done_cyc_cnt++;
                if (led == 8'hF0 || led == 8'h0F) begin
                    if (blink_samples > 0 && led != last_blink) blink_changes++;
                    blink_samples++;
                    last_blink = led;
                end
            end
            prev_drop = hs_bus.drop_req;
            prev_chg  = hs_bus.chg_req;
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int n, cnt;
        clr_counts();
        repeat (3) step();
        check("rst:credit", 32'(credit), 32'd0);
        check("rst:led", 32'(led), 32'h00);
        check("rst:drop_req", 32'(hs_bus.drop_req), 32'd0);
        check("rst:chg_req", 32'(hs_bus.chg_req), 32'd0);
        check("rst:outs", 32'({coin_rej, vend_done, fault}), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst:state", 32'(dbg.state), 32'(ST_IDLE));

        // Directed transactions.
        load(3, 2, 2, 1); run_txn("exact", 1'b0);
        load(3, 2, 2, 2); run_txn("overpay", 1'b0);
        load(1, 3, 0, 0); run_txn("simul", 1'b1);
        load(2, 2, 1, 0); run_txn("cancel", 1'b1);

        // Inactivity refund with a rejected coin during the refund.
        clr_counts();
        coin05 = 1'b1; step(); coin05 = 1'b0;
        check("inact:credit", 32'(credit), 32'd1);
        repeat (IDLE_TO - 1) step();
        check("inact:still_collect", 32'(dbg.state), 32'(ST_COLLECT));
        step();
        check("inact:refund", 32'(dbg.state), 32'(ST_REFUND));
        coin10 = 1'b1; step(); coin10 = 1'b0;
        check("inact:coin_rej", 32'(coin_rej), 32'd1);
        check("inact:rej_credit", 32'(credit), 32'd1);
        step();
        check("inact:rej_pulse", 32'(coin_rej), 32'd0);
        wait_idle("inact:idle", 200);
        check("inact:chg", 32'(chg_cnt), 32'd1);
        check("inact:drops", 32'(drop_cnt), 32'd0);
        check("inact:credit_end", 32'(credit), 32'd0);

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            ack_dly = int'($urandom_range(1, 4));
            n = int'($urandom_range(1, 4));
            cq.delete();
            for (int i = 0; i < n; i++) cq.push_back(int'($urandom_range(1, 3)));
            run_txn($sformatf("rand%0d", t), bit'($urandom_range(0, 1)));
        end
        ack_dly = 3;

        // Dispenser never acknowledges: fault, then asynchronous reset.
        clr_counts();
        resp_en = 1'b0;
        load(3, 2, 2, 2);
        foreach (cq[i]) begin
            coin10 = 1'b1; step(); coin10 = 1'b0;
        end
        cnt = 0;
        while (!fault && cnt < 60) begin
            step();
            cnt++;
        end
        check("fault:flag", 32'(fault), 32'd1);
        check("fault:drop_req", 32'(hs_bus.drop_req), 32'd0);
        check("fault:drops", 32'(drop_cnt), 32'd1);
        step();
        check("fault:led", 32'(led), 32'hFF);
        check("fault:credit", 32'(credit), 32'd6);
        check("fault:chg_req", 32'(hs_bus.chg_req), 32'd0);
        coin05 = 1'b1; step(); coin05 = 1'b0;
        check("fault:coin_rej", 32'(coin_rej), 32'd1);
        check("fault:frozen", 32'(credit), 32'd6);
        check("fault:sticky", 32'(fault), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst:fault", 32'(fault), 32'd0);
        check("arst:credit", 32'(credit), 32'd0);
        check("arst:led", 32'(led), 32'h00);
        check("arst:state", 32'(dbg.state), 32'(ST_IDLE));
        step();
        rst_n = 1'b1;
        resp_en = 1'b1;
        step();

        // Normal operation after the reset.
        load(3, 2, 2, 1); run_txn("post_rst", 1'b0);

        if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin : watchdog
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
